// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq -- command sequencer for an external multiply-accumulate unit.
//
// A command (start + len) clears the downstream accumulator, then consumes
// len operand pairs from two valid/ready streams. Each consumed pair is
// registered and presented to the MAC with a one-cycle accumulate pulse.
// After two drain cycles (one for the final accumulate, one for the MAC
// output to settle into mac_cout), the accumulator value is captured and
// offered on the result stream until it is accepted.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   start, len              command strobe and pair count, sampled in IDLE only
//   busy                    high whenever a command is in progress
//   a_valid/a_data/a_ready  operand-A stream
//   b_valid/b_data/b_ready  operand-B stream (consumed only jointly with A)
//   mac_en, mac_clr         accumulate pulse / accumulator clear to the MAC
//   mac_a, mac_b            registered operands to the MAC
//   mac_cout                accumulator value returned by the MAC
//   res_valid/res_data/res_ready  result stream (3*DATA_WIDTH bits, wraps)
// ---------------------------------------------------------------------------
module mac_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_ready,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_a,
  output logic [DATA_WIDTH-1:0]   mac_b,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    res_valid,
  output logic [3*DATA_WIDTH-1:0] res_data,
  input  logic                    res_ready
);

  localparam int RES_W = 3 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_WIDTH-1:0]    cnt;
  logic [LEN_WIDTH-1:0]    cnt_nxt;
  logic                    fire;

  logic [DATA_WIDTH-1:0]   a_p0;
  logic [DATA_WIDTH-1:0]   b_p0;
  logic                    vld_p0;
  logic [RES_W-1:0]        res_p1;

  // -------------------------------------------------------------------------
  // Control: next-state and per-state strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    busy      = 1'b1;
    mac_clr   = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    res_valid = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_nxt   = len;
          state_nxt = S_CLEAR;
        end
      end

      S_CLEAR: begin
        mac_clr = 1'b1;
        // A zero-length command skips streaming and reports the cleared value.
        state_nxt = (cnt != '0) ? S_STREAM : S_DRAIN1;
      end

      S_STREAM: begin
        // Both operands move together; a lone valid never produces a ready.
        if (a_valid && b_valid) begin
          fire    = 1'b1;
          a_ready = 1'b1;
          b_ready = 1'b1;
          cnt_nxt = cnt - LEN_WIDTH'(1);
          if (cnt == LEN_WIDTH'(1)) begin
            state_nxt = S_DRAIN1;
          end
        end
      end

      // DRAIN1 covers the last accumulate pulse, DRAIN2 lets mac_cout settle.
      S_DRAIN1: state_nxt = S_DRAIN2;
      S_DRAIN2: state_nxt = S_DONE;

      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p0: operand registers and accumulate pulse toward the MAC
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= fire;
      if (fire) begin
        a_p0 <= a_data;
        b_p0 <= b_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: result capture from the MAC on the way out of DRAIN2
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
    end else if (state == S_DRAIN2) begin
      res_p1 <= mac_cout;
    end
  end

  assign mac_a    = a_p0;
  assign mac_b    = b_p0;
  assign mac_en   = vld_p0;
  assign res_data = res_p1;

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 Parameter LEN_WIDTH, default 8, width of the vector-length field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  command strobe; sampled only in IDLE.
REQ-006 len  input  LEN_WIDTH  number of operand pairs for the command; sampled with start.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 a_valid / a_data / a_ready  input 1 / input DATA_WIDTH / output 1  operand-A stream.
REQ-009 b_valid / b_data / b_ready  input 1 / input DATA_WIDTH / output 1  operand-B stream.
REQ-010 mac_en  output  1  accumulate enable to the downstream MAC.
REQ-011 mac_clr  output  1  accumulator clear to the downstream MAC.
REQ-012 mac_a / mac_b  output  DATA_WIDTH each  registered operands to the MAC.
REQ-013 mac_cout  input  3*DATA_WIDTH  MAC accumulator value.
REQ-014 res_valid / res_data / res_ready  output 1 / output 3*DATA_WIDTH / input 1  result stream.

Function
REQ-015 FSM states: IDLE, CLEAR, STREAM, DRAIN1, DRAIN2, DONE.
REQ-016 IDLE: start=1 latches len into a remaining-pair counter and moves to CLEAR; start=0 stays IDLE.
REQ-017 CLEAR: mac_clr=1 for exactly this one cycle; next state STREAM if counter != 0, else DRAIN1.
REQ-018 mac_clr SHALL be 0 in every state other than CLEAR.
REQ-019 STREAM: a pair fires in a cycle when a_valid=1 and b_valid=1; a_ready=b_ready=1 only in that cycle; neither stream is ever consumed alone.
REQ-020 a_ready and b_ready SHALL be 0 in every state other than STREAM.
REQ-021 On a fire, mac_a<=a_data, mac_b<=b_data, mac_en<=1 at the same edge, and the counter decrements by 1.
REQ-022 mac_en is a registered pulse: it is 1 only in the cycle after a fire and 0 in all other cycles; mac_a/mac_b hold their last value otherwise.
REQ-023 The fire that decrements the counter from 1 to 0 SHALL move the FSM to DRAIN1 at the same edge.
REQ-024 DRAIN1 → DRAIN2 → DONE unconditionally, one cycle each; res_data<=mac_cout at the edge leaving DRAIN2.
REQ-025 DONE: res_valid=1 and res_data stable until res_ready=1; on that edge go to IDLE and drop res_valid.
REQ-026 res_data width is 3*DATA_WIDTH; no saturation; the value is whatever the MAC holds (MAC wraps modulo 2^(3*DATA_WIDTH)).
REQ-027 start outside IDLE SHALL be ignored, with no effect on counter or state.
REQ-028 Latency with both streams always valid: start sampled in cycle 0 → res_valid first high in cycle len+4; for len=0, in cycle 4 with res_data=0.
REQ-029 Stream bubbles (either valid low) SHALL stall STREAM with no counter change and mac_en=0 in the following cycle.

Reset
REQ-030 On rst_n=0, at any time including mid-command: state=IDLE, counter=0, busy=0, mac_en=0, mac_clr=0, mac_a=0, mac_b=0, a_ready=b_ready=0, res_valid=0, res_data=0.
REQ-031 After reset deassertion, the first command SHALL behave identically to a command issued after power-up.

Verification
REQ-032 len=3, A={1,2,3}, B={4,5,6} always valid, res_ready=1 → mac_clr in cycle 1, mac_en in cycles 3-5, res_valid in cycle 7 with res_data=32.
REQ-033 Same data, a_valid low in cycle 3 and b_valid low in cycle 5 → no fire in those cycles, res_data=32, res_valid 2 cycles later than in REQ-032.
REQ-034 len=0 → one mac_clr pulse, no a_ready/b_ready/mac_en, res_valid in cycle 4 with res_data=0.
REQ-035 len=255, all operands 255 → res_data=16581375; res_ready held low 10 cycles → res_valid and res_data held; start pulses during busy ignored.
REQ-036 rst_n asserted after 2 of 5 pairs fire → all outputs at reset values immediately; new command len=1, A=7, B=9 → res_data=63.
